// File: rtl/shared_mem_arbiter_pkg.sv
// rtl/shared_mem_arbiter_pkg.sv - shared types and constants for the shared memory arbiter
package shared_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_NPU = 1'b1
    } owner_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int DEF_RD_LAT       = 1;
    localparam int DEF_STARVE_LIMIT = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_arb_req_latch.sv
// rtl/shared_mem_arbiter_arb_req_latch.sv - holds the granted request and drives it onto the memory port
module arb_req_latch
    import shared_mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          grant_i,
    input  logic          owner_i,
    input  logic          op_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wd_i,
    input  logic          issue_i,
    output logic          owner_o,
    output logic          op_o,
    output logic          mem_rd_o,
    output logic          mem_wr_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wd_o
);

    logic          owner_q;
    logic          op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wd_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q <= OWN_CPU;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wd_q    <= '0;
        end else if (grant_i) begin
            owner_q <= owner_i;
            op_q    <= op_i;
            addr_q  <= addr_i;
            wd_q    <= wd_i;
        end
    end

    // The memory bus is quiet outside the single issue cycle.
    assign owner_o    = owner_q;
    assign op_o       = op_q;
    assign mem_rd_o   = issue_i & (op_q == OP_RD);
    assign mem_wr_o   = issue_i & (op_q == OP_WR);
    assign mem_addr_o = issue_i ? addr_q : '0;
    assign mem_wd_o   = issue_i ? wd_q : '0;

endmodule

// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - CPU/NPU shared memory arbiter with starvation guard; ARB_PERF_EN adds perf counters
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int RD_LAT       = DEF_RD_LAT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wd,
    output logic          cpu_stall,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          npu_rd,
    input  logic          npu_wr,
    input  logic [AW-1:0] npu_addr,
    input  logic [DW-1:0] npu_wd,
    output logic          npu_done,
    output logic [DW-1:0] npu_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [15:0]   perf_conflicts,
    output logic [15:0]   perf_starve
`endif
);

    localparam logic [2:0] LAT_LAST  = 3'(RD_LAT - 1);
    localparam logic [7:0] STARVE_TH = 8'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    logic [2:0]    lat_q, lat_d;
    logic [7:0]    cpu_wait_q, cpu_wait_d;
    logic          cpu_done_q, npu_done_q;
    logic [DW-1:0] cpu_rdata_q, npu_rdata_q;

    logic          cpu_req, npu_req, starve;
    logic          grant, capture, issue;
    logic          win_owner, win_op;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wd;
    logic          owner_q, op_q;

    // A requester still showing its done pulse has not yet had a chance to drop.
    assign cpu_req = (cpu_rd | cpu_wr) & ~cpu_done_q;
    assign npu_req = (npu_rd | npu_wr) & ~npu_done_q;
    assign starve  = cpu_wait_q >= STARVE_TH;
    assign issue   = (state_q == ST_ISSUE);

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        grant     = 1'b0;
        capture   = 1'b0;
        win_owner = OWN_CPU;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req | npu_req) begin
                    grant   = 1'b1;
                    state_d = ST_ISSUE;
                    if (starve && cpu_req) begin
                        win_owner = OWN_CPU;
                    end else if (npu_req) begin
                        win_owner = OWN_NPU;
                    end else begin
                        win_owner = OWN_CPU;
                    end
                end
            end
            ST_ISSUE: begin
                lat_d   = '0;
                state_d = (op_q == OP_WR) ? ST_DONE : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (lat_q == LAT_LAST) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write wins when a requester raises rd and wr together.
    always_comb begin
        win_op   = OP_RD;
        win_addr = cpu_addr;
        win_wd   = cpu_wd;
        if (win_owner == OWN_NPU) begin
            win_op   = npu_wr ? OP_WR : OP_RD;
            win_addr = npu_addr;
            win_wd   = npu_wd;
        end else begin
            win_op   = cpu_wr ? OP_WR : OP_RD;
        end
    end

    always_comb begin
        cpu_wait_d = cpu_wait_q;
        if (!cpu_req) begin
            cpu_wait_d = '0;
        end else if (grant && (win_owner == OWN_CPU)) begin
            cpu_wait_d = '0;
        end else if (((state_q != ST_IDLE) && (owner_q != OWN_CPU)) ||
                     (grant && (win_owner == OWN_NPU))) begin
            cpu_wait_d = sat_inc8(cpu_wait_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            cpu_wait_q  <= '0;
            cpu_done_q  <= 1'b0;
            npu_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            npu_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            cpu_wait_q <= cpu_wait_d;
            cpu_done_q <= (state_d == ST_DONE) && (owner_q == OWN_CPU);
            npu_done_q <= (state_d == ST_DONE) && (owner_q == OWN_NPU);
            if (capture && (owner_q == OWN_CPU)) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (capture && (owner_q == OWN_NPU)) begin
                npu_rdata_q <= mem_rdata;
            end
        end
    end

    arb_req_latch #(
        .AW(AW),
        .DW(DW)
    ) u_req_latch (
        .clk        (clk),
        .rst        (rst),
        .grant_i    (grant),
        .owner_i    (win_owner),
        .op_i       (win_op),
        .addr_i     (win_addr),
        .wd_i       (win_wd),
        .issue_i    (issue),
        .owner_o    (owner_q),
        .op_o       (op_q),
        .mem_rd_o   (mem_rd),
        .mem_wr_o   (mem_wr),
        .mem_addr_o (mem_addr),
        .mem_wd_o   (mem_wd)
    );

    assign cpu_stall = (cpu_rd | cpu_wr) & ~cpu_done_q;
    assign cpu_done  = cpu_done_q;
    assign npu_done  = npu_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign npu_rdata = npu_rdata_q;

`ifdef ARB_PERF_EN
    logic [15:0] perf_conf_q, perf_starve_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_conf_q   <= '0;
            perf_starve_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && cpu_req && npu_req) begin
                perf_conf_q <= sat_inc16(perf_conf_q);
            end
            if (grant && starve && cpu_req) begin
                perf_starve_q <= sat_inc16(perf_starve_q);
            end
        end
    end

    assign perf_conflicts = perf_conf_q;
    assign perf_starve    = perf_starve_q;
`endif

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - scoreboard bench for shared_mem_arbiter
module tb_shared_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr, npu_rd, npu_wr;
    logic [31:0] cpu_addr, cpu_wd, npu_addr, npu_wd;
    logic        cpu_stall, cpu_done, npu_done;
    logic [31:0] cpu_rdata, npu_rdata;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wd;
    logic [31:0] mem_rdata = '0;

    shared_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wd    (cpu_wd),
        .cpu_stall (cpu_stall),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .npu_rd    (npu_rd),
        .npu_wr    (npu_wr),
        .npu_addr  (npu_addr),
        .npu_wd    (npu_wd),
        .npu_done  (npu_done),
        .npu_rdata (npu_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        int          cyc;
    } exp_t;

    exp_t cpu_q[$];
    exp_t npu_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rd_strobe = 0;
    int n_wr_strobe = 0;
    int n_both_strobe = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Memory model: RD_LAT=1, unwritten words return an address-derived pattern.
    logic [31:0] mem_m [logic [31:0]];

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : (a ^ 32'hC0DE0000);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) mem_m[mem_addr] = mem_wd;
        if (mem_rd) mem_rdata <= mem_peek(mem_addr);
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (mem_rd) n_rd_strobe++;
        if (mem_wr) n_wr_strobe++;
        if (mem_rd && mem_wr) n_both_strobe++;
        if (cpu_done) begin
            if (cpu_q.size() == 0) begin
                chk("cpu_unexpected_done", 1, 0);
            end else begin
                e = cpu_q.pop_front();
                chk("cpu_done_cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk_data) chk("cpu_rdata", cpu_rdata, e.data);
            end
        end
        if (npu_done) begin
            if (npu_q.size() == 0) begin
                chk("npu_unexpected_done", 1, 0);
            end else begin
                e = npu_q.pop_front();
                chk("npu_done_cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk_data) chk("npu_rdata", npu_rdata, e.data);
            end
        end
    end

    task automatic wait_done(input bit npu, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(npu ? npu_done : cpu_done) && n < budget);
        if (!(npu ? npu_done : cpu_done)) chk(npu ? "npu_timeout" : "cpu_timeout", 0, 1);
    endtask

    task automatic npu_reads(input int count, input logic [31:0] base);
        for (int k = 0; k < count; k++) begin
            npu_addr = base + 32'(4 * k);
            npu_rd   = 1'b1;
            wait_done(1'b1, 30);
        end
        npu_rd = 1'b0;
    endtask

    task automatic cpu_single(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wd = d;
        wait_done(1'b0, 30);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, rd0, wr0;
        rst = 1'b0;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wd = '0;
        npu_rd = 0; npu_wr = 0; npu_addr = '0; npu_wd = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_npu_done", npu_done, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_npu_rdata", npu_rdata, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        rst = 1'b1;
        @(negedge clk);

        // CPU write alone
        cpu_wr = 1'b1; cpu_addr = 32'h40; cpu_wd = 32'hDEADBEEF;
        t = cyc;
        cpu_q.push_back('{data: 32'h0, chk_data: 1'b0, cyc: t + 2});
        #1 chk("t1_stall_T", cpu_stall, 1);
        @(negedge clk);
        chk("t1_mem_wr", mem_wr, 1);
        chk("t1_mem_rd", mem_rd, 0);
        chk("t1_mem_addr", mem_addr, 32'h40);
        chk("t1_mem_wd", mem_wd, 32'hDEADBEEF);
        chk("t1_stall_T1", cpu_stall, 1);
        @(negedge clk);
        chk("t1_done", cpu_done, 1);
        chk("t1_stall_done", cpu_stall, 0);
        cpu_wr = 1'b0;
        @(negedge clk);
        chk("t1_mem_written", mem_peek(32'h40), 32'hDEADBEEF);

        // NPU read alone
        mem_m[32'h100] = 32'h12345678;
        npu_rd = 1'b1; npu_addr = 32'h100;
        t = cyc;
        npu_q.push_back('{data: 32'h12345678, chk_data: 1'b1, cyc: t + 3});
        @(negedge clk);
        chk("t2_mem_rd", mem_rd, 1);
        chk("t2_mem_addr", mem_addr, 32'h100);
        wait_done(1'b1, 10);
        npu_rd = 1'b0;
        chk("t2_cpu_rdata_hold", cpu_rdata, 0);
        @(negedge clk);

        // Simultaneous requests: NPU first, CPU after
        t = cyc;
        npu_q.push_back('{data: 32'h0, chk_data: 1'b0, cyc: t + 2});
        cpu_q.push_back('{data: mem_peek(32'h44), chk_data: 1'b1, cyc: t + 6});
        fork
            begin
                npu_wr = 1'b1; npu_addr = 32'h80; npu_wd = 32'h11112222;
                wait_done(1'b1, 20);
                npu_wr = 1'b0;
            end
            cpu_single(1'b1, 1'b0, 32'h44, 32'h0);
        join
        chk("t3_npu_write", mem_peek(32'h80), 32'h11112222);
        @(negedge clk);

        // Starvation: NPU streams reads, CPU forced in after 8 wait cycles
        t = cyc;
        npu_q.push_back('{data: mem_peek(32'h300), chk_data: 1'b1, cyc: t + 3});
        npu_q.push_back('{data: mem_peek(32'h304), chk_data: 1'b1, cyc: t + 7});
        cpu_q.push_back('{data: mem_peek(32'h500), chk_data: 1'b1, cyc: t + 11});
        npu_q.push_back('{data: mem_peek(32'h308), chk_data: 1'b1, cyc: t + 15});
        npu_q.push_back('{data: mem_peek(32'h30C), chk_data: 1'b1, cyc: t + 19});
        fork
            npu_reads(4, 32'h300);
            cpu_single(1'b1, 1'b0, 32'h500, 32'h0);
        join
        @(negedge clk);

        // Reset in WAIT_RD drops the access; re-issue completes
        mem_m[32'h200] = 32'hCAFEF00D;
        npu_rd = 1'b1; npu_addr = 32'h200;
        @(negedge clk);
        chk("t5_issue_rd", mem_rd, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_mem_rd", mem_rd, 0);
        chk("t5_mem_wr", mem_wr, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_npu_done", npu_done, 0);
        chk("t5_npu_rdata", npu_rdata, 0);
        chk("t5_cpu_rdata", cpu_rdata, 0);
        chk("t5_cpu_stall", cpu_stall, 0);
        rst = 1'b1;
        t = cyc;
        npu_q.push_back('{data: 32'hCAFEF00D, chk_data: 1'b1, cyc: t + 3});
        wait_done(1'b1, 10);
        npu_rd = 1'b0;
        @(negedge clk);

        // rd and wr together behave as a write
        rd0 = n_rd_strobe; wr0 = n_wr_strobe;
        t = cyc;
        cpu_q.push_back('{data: 32'h0, chk_data: 1'b0, cyc: t + 2});
        cpu_single(1'b1, 1'b1, 32'h60, 32'hA5A5A5A5);
        @(negedge clk);
        chk("t6_wr_strobes", 64'(n_wr_strobe - wr0), 1);
        chk("t6_rd_strobes", 64'(n_rd_strobe - rd0), 0);
        chk("t6_mem", mem_peek(32'h60), 32'hA5A5A5A5);
        chk("t6_cpu_rdata_hold", cpu_rdata, 0);

        repeat (3) @(negedge clk);
        chk("rd_wr_overlap", 64'(n_both_strobe), 0);
        chk("cpu_q_drained", 64'(cpu_q.size()), 0);
        chk("npu_q_drained", 64'(npu_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Sequences the single shared data memory between the CPU load/store path and the NPU operand/result path.
- Replaces the ad-hoc race-hazard signalling with an explicit grant/done handshake.
- NPU has priority while it runs; a starvation counter guarantees CPU forward progress.
- Sits between TOPCPU/npu and the memory macro, on the CPU-side clock domain. One access is outstanding at a time.

Parameters:
- AW, 32, address width
- DW, 32, data width
- RD_LAT, 1, memory read latency in cycles (1..4); mem_rdata is valid RD_LAT cycles after the mem_rd cycle
- STARVE_LIMIT, 8, consecutive CPU wait cycles before the CPU is forced to win arbitration (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- cpu_rd  in  1  CPU read request (level)
- cpu_wr  in  1  CPU write request (level)
- cpu_addr  in  AW  CPU address
- cpu_wd  in  DW  CPU write data
- cpu_stall  out  1  CPU request pending and not yet done
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data, valid when cpu_done
- npu_rd  in  1  NPU read request (level)
- npu_wr  in  1  NPU write request (level)
- npu_addr  in  AW  NPU address
- npu_wd  in  DW  NPU write data
- npu_done  out  1  one-cycle completion pulse
- npu_rdata  out  DW  read data, valid when npu_done
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset (rst=0 at an edge): state=IDLE. All outputs are 0: mem_*, *_done, *_rdata, cpu_stall. The wait counter is 0. Any in-flight access is dropped and the requester must re-issue it.
- Request hold rule: a requester holds rd/wr, addr and wd stable until its done pulse. Operands are latched at grant, so later changes are ignored.
- If rd and wr are both high on one requester, it is treated as a write.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE: if any request is valid, pick a winner. Latch owner, op, addr and wd. Go to ISSUE.
  - A requester whose done is high in this cycle is masked as not requesting.
- Priority:
  - If cpu_wait_cnt >= STARVE_LIMIT, the CPU wins.
  - Otherwise the NPU wins if it requests.
  - Otherwise the CPU wins.
- ISSUE: drive mem_rd or mem_wr high for exactly 1 cycle with the latched addr/wd. A write goes to DONE; a read goes to WAIT_RD.
- WAIT_RD: count RD_LAT cycles from the ISSUE cycle. On the last one, capture mem_rdata into the owner's rdata register, then go to DONE.
- DONE: pulse the owner's done for 1 cycle with rdata valid. The next state is IDLE, which can grant in the following cycle.
  - Latency from a request seen in IDLE at cycle T: write done at T+2; read done at T+2+RD_LAT.
- Rdata retention: the non-owner's rdata holds its last value. The owner's rdata holds until its next read completes.
- cpu_stall = (cpu_rd|cpu_wr) & ~cpu_done. It is combinational from the request and the registered done.
- Wait counter:
  - Increments (saturating at 255) each cycle the CPU requests and the current owner is not the CPU, or the state is IDLE and the NPU wins.
  - Clears on a CPU grant or when the CPU is not requesting.
- mem_rd and mem_wr are never high together and are never high outside ISSUE.

Optional Feature:
- Macro ARB_PERF_EN.
- When defined:
  - Adds outputs perf_conflicts (16 bit): saturating count of IDLE cycles where both requesters are valid.
  - Adds perf_starve (16 bit): saturating count of forced CPU grants.
  - Both reset to 0.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/ISSUE/WAIT_RD/DONE);
  - the owner encoding (OWN_CPU=0, OWN_NPU=1);
  - the op encoding (OP_RD, OP_WR);
  - the default RD_LAT and STARVE_LIMIT constants.
- One sub-module, arb_req_latch: latches owner/op/addr/wd at grant and muxes them onto mem_*.

Test Plan:
- CPU write addr=0x40 wd=0xDEADBEEF alone -> mem_wr=1 at T+1 with mem_addr=0x40; cpu_done at T+2; cpu_stall high T..T+1.
- NPU read addr=0x100, RD_LAT=1, memory returns 0x12345678 -> mem_rd at T+1; npu_done at T+3 with npu_rdata=0x12345678.
- CPU and NPU both request in the same IDLE cycle -> NPU granted first, then CPU granted after npu_done; no cycle has mem_rd & mem_wr.
- NPU requests continuously with back-to-back reads; CPU read pending; STARVE_LIMIT=8 -> CPU granted once the counter reaches 8; the NPU resumes after cpu_done.
- Reset asserted during WAIT_RD -> next cycle all outputs are 0, state is IDLE, no done pulse; the re-issued request completes normally.
- Both rd and wr high on the CPU with wd=0xA5A5A5A5 -> a single mem_wr; mem_rd never asserted; cpu_done after 2 cycles.
